rob: RTL and testbench
======================

ROB -- requirements
Module: rob

Interface
REQ-001 SHALL have parameter ROB_SIZE, default 16, number of entries (power of two).
REQ-002 SHALL have parameter ROB_IDX_W, default 4, log2(ROB_SIZE).
REQ-003 SHALL have: clk  in  1  system clock; one clock domain.
REQ-004 SHALL have: rst_in  in  1  synchronous, active-high reset.
REQ-005 SHALL have: rdy_in  in  1  when low, all state and outputs hold.
REQ-006 SHALL have: de_in_en / de_type_in[1:0] / de_dest_in[4:0] / de_pred_jump_in  in  allocate request; type 0 = REG, 1 = BRANCH, 2 = STORE; dest register; predicted taken.
REQ-007 SHALL have: de_rob_idx_out  out  ROB_IDX_W  index the next allocation receives (tail); rob_full_out  out  1  no free entry.
REQ-008 SHALL have: rs1_dep_in, rs2_dep_in  in  ROB_IDX_W  entry indices looked up for operands.
REQ-009 SHALL have: rob_rs1_busy_out, rob_rs2_busy_out  out  1; rob_rs1_val_out, rob_rs2_val_out  out  32  lookup results.
REQ-010 SHALL have: alu_en, alu_idx, alu_val[31:0], alu_jump, alu_target[31:0]  in  ALU broadcast, with actual branch outcome and correct next PC.
REQ-011 SHALL have: lsb_en, lsb_idx, lsb_val[31:0]  in  load/store broadcast.
REQ-012 SHALL have: rob_in_en, rob_idx_out, rob_dest_out[4:0], rob_val_out[31:0]  out  register commit to the register file.
REQ-013 SHALL have: store_commit_out, store_idx_out  out  store release to the LSB; roll_back  out  1; rollback_pc_out  out  32.

Function
REQ-014 SHALL be a circular buffer with head, tail, and count registers (count width ROB_IDX_W+1); each entry holds valid, ready, type, dest, value, pred_jump, jump, and target.
REQ-015 SHALL drive rob_full_out = (count == ROB_SIZE) and de_rob_idx_out = tail, both combinationally.
REQ-016 SHALL, on de_in_en (the issuer never asserts it while full), write the entry at tail with valid=1 and ready=0, and advance tail by 1 modulo ROB_SIZE.
REQ-017 SHALL, on alu_en/lsb_en, set ready=1 and capture the value (and jump/target for ALU) at the given index; if both ports target the same index, ALU wins.
REQ-018 SHALL drive lookup busy = !ready of the entry, unless a same-cycle broadcast hits that index; then busy=0 and the value is bypassed (ALU before LSB).
REQ-019 SHALL commit at most one entry per cycle, when the head entry is valid and ready: head += 1 and the entry is cleared.
REQ-020 SHALL register commit outputs, one cycle after the decision and pulsed for exactly one cycle: REG -> rob_in_en=1 with idx/dest/value; STORE -> store_commit_out=1; BRANCH -> no register write.
REQ-021 SHALL, on a BRANCH commit with jump != pred_jump, drive roll_back=1 and rollback_pc_out=target for one cycle the next cycle, and in the same edge clear every valid bit and set head=tail=count=0.
REQ-022 SHALL ignore de_in_en and broadcasts in a cycle where roll_back is high.
REQ-023 SHALL, on simultaneous allocate and commit, leave count unchanged; both head and tail still advance.
REQ-024 SHALL wrap head and tail from ROB_SIZE-1 to 0.
REQ-025 SHALL allow an allocation at tail while the head entry at another index commits, including the case where the buffer was full at the start of the cycle.

Reset
REQ-026 SHALL, on rst_in, clear all valid and ready bits, set head=tail=count=0, and drive every output register to 0 (rob_in_en, store_commit_out, roll_back, rollback_pc_out, rob_*_out).
REQ-027 SHALL have reset override rdy_in and any in-flight commit or rollback; nothing is emitted in the cycle after reset.

Verification
REQ-028 SHALL verify: issue REG dest x5 at idx 0; ALU writes idx 0 value 0x1234 -> next-cycle rob_in_en=1, idx 0, dest 5, val 0x1234, for one cycle.
REQ-029 SHALL verify: fill 16 entries -> rob_full_out=1; complete and commit the head -> full drops; next allocation gets idx 0 after wrap.
REQ-030 SHALL verify: lookup idx 3 while ALU broadcasts idx 3 value 7 in the same cycle -> busy=0, val=7.
REQ-031 SHALL verify: BRANCH pred 0, ALU jump=1, target 0x100 -> roll_back=1 and rollback_pc_out=0x100 for one cycle; count=0; younger ready REG entries never commit.
REQ-032 SHALL verify: out-of-order completion (idx 1 before idx 0) -> commits in order 0, 1; rdy_in low for 3 cycles holds all state with no duplicate rob_in_en.
REQ-033 SHALL verify: rst_in asserted with 5 valid entries -> next cycle count=0 and all outputs 0.

Source files
------------

// File: rtl/rob.sv
// rtl/rob.sv - reorder buffer: in-order commit, operand lookup with broadcast bypass, branch rollback
module rob #(
    parameter int ROB_SIZE  = 16,
    parameter int ROB_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_in,
    input  logic                 rdy_in,

    input  logic                 de_in_en,
    input  logic [1:0]           de_type_in,
    input  logic [4:0]           de_dest_in,
    input  logic                 de_pred_jump_in,
    output logic [ROB_IDX_W-1:0] de_rob_idx_out,
    output logic                 rob_full_out,

    input  logic [ROB_IDX_W-1:0] rs1_dep_in,
    input  logic [ROB_IDX_W-1:0] rs2_dep_in,
    output logic                 rob_rs1_busy_out,
    output logic                 rob_rs2_busy_out,
    output logic [31:0]          rob_rs1_val_out,
    output logic [31:0]          rob_rs2_val_out,

    input  logic                 alu_en,
    input  logic [ROB_IDX_W-1:0] alu_idx,
    input  logic [31:0]          alu_val,
    input  logic                 alu_jump,
    input  logic [31:0]          alu_target,

    input  logic                 lsb_en,
    input  logic [ROB_IDX_W-1:0] lsb_idx,
    input  logic [31:0]          lsb_val,

    output logic                 rob_in_en,
    output logic [ROB_IDX_W-1:0] rob_idx_out,
    output logic [4:0]           rob_dest_out,
    output logic [31:0]          rob_val_out,

    output logic                 store_commit_out,
    output logic [ROB_IDX_W-1:0] store_idx_out,
    output logic                 roll_back,
    output logic [31:0]          rollback_pc_out
);

    localparam logic [1:0] TYPE_REG    = 2'd0;
    localparam logic [1:0] TYPE_BRANCH = 2'd1;
    localparam logic [1:0] TYPE_STORE  = 2'd2;

    logic [ROB_SIZE-1:0] valid_q;
    logic [ROB_SIZE-1:0] ready_q;
    logic [ROB_SIZE-1:0] pred_q;
    logic [ROB_SIZE-1:0] jump_q;
    logic [1:0]          type_q   [ROB_SIZE];
    logic [4:0]          dest_q   [ROB_SIZE];
    logic [31:0]         val_q    [ROB_SIZE];
    logic [31:0]         target_q [ROB_SIZE];

    logic [ROB_IDX_W-1:0] head_q;
    logic [ROB_IDX_W-1:0] tail_q;
    logic [ROB_IDX_W:0]   count_q;

    logic accept;
    logic alloc;
    logic alu_wr;
    logic lsb_wr;
    logic commit;
    logic mispredict;

    assign rob_full_out   = (count_q == (ROB_IDX_W+1)'(ROB_SIZE));
    assign de_rob_idx_out = tail_q;

    // The cycle showing roll_back is the one right after the flush; anything
    // the front end or execution units send in it belongs to the squashed path.
    assign accept     = rdy_in && !roll_back;
    assign alloc      = accept && de_in_en;
    assign alu_wr     = accept && alu_en;
    assign lsb_wr     = accept && lsb_en;
    assign commit     = rdy_in && valid_q[head_q] && ready_q[head_q];
    assign mispredict = commit && (type_q[head_q] == TYPE_BRANCH)
                        && (jump_q[head_q] != pred_q[head_q]);

    // Operand lookup; ALU is applied last so it takes priority over LSB.
    always_comb begin
        rob_rs1_busy_out = !ready_q[rs1_dep_in];
        rob_rs1_val_out  = val_q[rs1_dep_in];
        rob_rs2_busy_out = !ready_q[rs2_dep_in];
        rob_rs2_val_out  = val_q[rs2_dep_in];
        if (lsb_wr && lsb_idx == rs1_dep_in) begin
            rob_rs1_busy_out = 1'b0;
            rob_rs1_val_out  = lsb_val;
        end
        if (alu_wr && alu_idx == rs1_dep_in) begin
            rob_rs1_busy_out = 1'b0;
            rob_rs1_val_out  = alu_val;
        end
        if (lsb_wr && lsb_idx == rs2_dep_in) begin
            rob_rs2_busy_out = 1'b0;
            rob_rs2_val_out  = lsb_val;
        end
        if (alu_wr && alu_idx == rs2_dep_in) begin
            rob_rs2_busy_out = 1'b0;
            rob_rs2_val_out  = alu_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            valid_q          <= '0;
            ready_q          <= '0;
            pred_q           <= '0;
            jump_q           <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                type_q[i]   <= '0;
                dest_q[i]   <= '0;
                val_q[i]    <= '0;
                target_q[i] <= '0;
            end
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            rob_in_en        <= 1'b0;
            rob_idx_out      <= '0;
            rob_dest_out     <= '0;
            rob_val_out      <= '0;
            store_commit_out <= 1'b0;
            store_idx_out    <= '0;
            roll_back        <= 1'b0;
            rollback_pc_out  <= '0;
        end else begin
            // Strobes are single-cycle even across a stall, so a held commit never repeats.
            rob_in_en        <= 1'b0;
            store_commit_out <= 1'b0;
            roll_back        <= 1'b0;
            rollback_pc_out  <= '0;
            if (rdy_in) begin
                if (lsb_wr) begin
                    ready_q[lsb_idx] <= 1'b1;
                    val_q[lsb_idx]   <= lsb_val;
                end
                if (alu_wr) begin
                    ready_q[alu_idx]  <= 1'b1;
                    val_q[alu_idx]    <= alu_val;
                    jump_q[alu_idx]   <= alu_jump;
                    target_q[alu_idx] <= alu_target;
                end

                if (commit) begin
                    valid_q[head_q] <= 1'b0;
                    ready_q[head_q] <= 1'b0;
                    case (type_q[head_q])
                        TYPE_REG: begin
                            rob_in_en    <= 1'b1;
                            rob_idx_out  <= head_q;
                            rob_dest_out <= dest_q[head_q];
                            rob_val_out  <= val_q[head_q];
                        end
                        TYPE_STORE: begin
                            store_commit_out <= 1'b1;
                            store_idx_out    <= head_q;
                        end
                        TYPE_BRANCH: begin
                            if (mispredict) begin
                                roll_back       <= 1'b1;
                                rollback_pc_out <= target_q[head_q];
                            end
                        end
                        default: ;
                    endcase
                end

                // Allocation lands after the commit clear: when full, tail == head.
                if (alloc) begin
                    valid_q[tail_q] <= 1'b1;
                    ready_q[tail_q] <= 1'b0;
                    type_q[tail_q]  <= de_type_in;
                    dest_q[tail_q]  <= de_dest_in;
                    pred_q[tail_q]  <= de_pred_jump_in;
                    jump_q[tail_q]  <= 1'b0;
                end

                if (mispredict) begin
                    valid_q <= '0;
                    ready_q <= '0;
                    head_q  <= '0;
                    tail_q  <= '0;
                    count_q <= '0;
                end else begin
                    head_q  <= head_q + ROB_IDX_W'(commit);
                    tail_q  <= tail_q + ROB_IDX_W'(alloc);
                    count_q <= count_q + (ROB_IDX_W+1)'(alloc) - (ROB_IDX_W+1)'(commit);
                end
            end
        end
    end

endmodule

// File: tb/tb_rob.sv
// tb/tb_rob.sv - directed table and sequence checks for the reorder buffer
module tb_rob;

    logic        clk = 1'b0;
    logic        rst_in, rdy_in;
    logic        de_in_en;
    logic [1:0]  de_type_in;
    logic [4:0]  de_dest_in;
    logic        de_pred_jump_in;
    logic [3:0]  de_rob_idx_out;
    logic        rob_full_out;
    logic [3:0]  rs1_dep_in, rs2_dep_in;
    logic        rob_rs1_busy_out, rob_rs2_busy_out;
    logic [31:0] rob_rs1_val_out, rob_rs2_val_out;
    logic        alu_en;
    logic [3:0]  alu_idx;
    logic [31:0] alu_val;
    logic        alu_jump;
    logic [31:0] alu_target;
    logic        lsb_en;
    logic [3:0]  lsb_idx;
    logic [31:0] lsb_val;
    logic        rob_in_en;
    logic [3:0]  rob_idx_out;
    logic [4:0]  rob_dest_out;
    logic [31:0] rob_val_out;
    logic        store_commit_out;
    logic [3:0]  store_idx_out;
    logic        roll_back;
    logic [31:0] rollback_pc_out;

    int n_chk  = 0;
    int n_fail = 0;

    rob #(.ROB_SIZE(16), .ROB_IDX_W(4)) dut (
        .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in),
        .de_in_en(de_in_en), .de_type_in(de_type_in), .de_dest_in(de_dest_in),
        .de_pred_jump_in(de_pred_jump_in), .de_rob_idx_out(de_rob_idx_out),
        .rob_full_out(rob_full_out),
        .rs1_dep_in(rs1_dep_in), .rs2_dep_in(rs2_dep_in),
        .rob_rs1_busy_out(rob_rs1_busy_out), .rob_rs2_busy_out(rob_rs2_busy_out),
        .rob_rs1_val_out(rob_rs1_val_out), .rob_rs2_val_out(rob_rs2_val_out),
        .alu_en(alu_en), .alu_idx(alu_idx), .alu_val(alu_val),
        .alu_jump(alu_jump), .alu_target(alu_target),
        .lsb_en(lsb_en), .lsb_idx(lsb_idx), .lsb_val(lsb_val),
        .rob_in_en(rob_in_en), .rob_idx_out(rob_idx_out),
        .rob_dest_out(rob_dest_out), .rob_val_out(rob_val_out),
        .store_commit_out(store_commit_out), .store_idx_out(store_idx_out),
        .roll_back(roll_back), .rollback_pc_out(rollback_pc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int de_en, ty, dest, pred;
        int a_en, a_idx, a_val, a_jump, a_tgt;
        int l_en, l_idx, l_val;
        int lk, rs1, b1, v1, rs2, b2, v2;
        int we, idx, wdest, wval, st, tail;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        rdy_in = 1'b1; de_in_en = 1'b0; de_type_in = 2'd0; de_dest_in = 5'd0;
        de_pred_jump_in = 1'b0; rs1_dep_in = 4'd0; rs2_dep_in = 4'd0;
        alu_en = 1'b0; alu_idx = 4'd0; alu_val = 32'd0; alu_jump = 1'b0; alu_target = 32'd0;
        lsb_en = 1'b0; lsb_idx = 4'd0; lsb_val = 32'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
    endtask

    task automatic alloc(input logic [1:0] ty, input logic [4:0] dest, input logic pred);
        idle();
        de_in_en = 1'b1; de_type_in = ty; de_dest_in = dest; de_pred_jump_in = pred;
    endtask

    task automatic alu(input logic [3:0] idx, input logic [31:0] val, input logic jmp,
                       input logic [31:0] tgt);
        idle();
        alu_en = 1'b1; alu_idx = idx; alu_val = val; alu_jump = jmp; alu_target = tgt;
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, ".rob_in_en"}, 32'(rob_in_en), 32'd0);
        chk({nm, ".store"}, 32'(store_commit_out), 32'd0);
        chk({nm, ".roll_back"}, 32'(roll_back), 32'd0);
    endtask

    task automatic chk_commit(input string nm, input int idx, input int dest, input int val);
        chk({nm, ".rob_in_en"}, 32'(rob_in_en), 32'd1);
        chk({nm, ".idx"}, 32'(rob_idx_out), 32'(idx));
        chk({nm, ".dest"}, 32'(rob_dest_out), 32'(dest));
        chk({nm, ".val"}, rob_val_out, 32'(val));
    endtask

    initial begin
        //          de   ty dst pr  aen ai aval        aj atgt       len li lval       lk rs1 b1 v1          rs2 b2 v2        we i dst wval       st tail
        vecs[0]  = '{1,  0, 5,  0,  0,  0, 0,          0, 0,         0,  0, 0,         1, 0,  1, 0,          1,  1, 0,        0, 0, 0, 0,         0, 1};
        vecs[1]  = '{0,  0, 0,  0,  1,  0, 'h1234,     0, 0,         0,  0, 0,         1, 0,  0, 'h1234,     1,  1, 0,        0, 0, 0, 0,         0, 1};
        vecs[2]  = '{0,  0, 0,  0,  0,  0, 0,          0, 0,         0,  0, 0,         1, 0,  0, 'h1234,     1,  1, 0,        1, 0, 5, 'h1234,    0, 1};
        vecs[3]  = '{0,  0, 0,  0,  0,  0, 0,          0, 0,         0,  0, 0,         0, 0,  0, 0,          0,  0, 0,        0, 0, 0, 0,         0, 1};
        vecs[4]  = '{1,  0, 6,  0,  0,  0, 0,          0, 0,         0,  0, 0,         0, 0,  0, 0,          0,  0, 0,        0, 0, 0, 0,         0, 2};
        vecs[5]  = '{1,  0, 7,  0,  0,  0, 0,          0, 0,         0,  0, 0,         0, 0,  0, 0,          0,  0, 0,        0, 0, 0, 0,         0, 3};
        vecs[6]  = '{1,  0, 8,  0,  1,  2, 'h22,       0, 0,         0,  0, 0,         1, 3,  1, 0,          2,  0, 'h22,     0, 0, 0, 0,         0, 4};
        vecs[7]  = '{0,  0, 0,  0,  1,  3, 7,          0, 0,         1,  3, 9,         1, 3,  0, 7,          2,  0, 'h22,     0, 0, 0, 0,         0, 4};
        vecs[8]  = '{0,  0, 0,  0,  0,  0, 0,          0, 0,         1,  1, 'h11,      1, 2,  0, 'h22,       1,  0, 'h11,     0, 0, 0, 0,         0, 4};
        vecs[9]  = '{0,  0, 0,  0,  0,  0, 0,          0, 0,         0,  0, 0,         0, 0,  0, 0,          0,  0, 0,        1, 1, 6, 'h11,      0, 4};
        vecs[10] = '{0,  0, 0,  0,  0,  0, 0,          0, 0,         0,  0, 0,         0, 0,  0, 0,          0,  0, 0,        1, 2, 7, 'h22,      0, 4};
        vecs[11] = '{0,  0, 0,  0,  0,  0, 0,          0, 0,         0,  0, 0,         0, 0,  0, 0,          0,  0, 0,        1, 3, 8, 7,         0, 4};
        vecs[12] = '{1,  2, 0,  0,  0,  0, 0,          0, 0,         0,  0, 0,         0, 0,  0, 0,          0,  0, 0,        0, 0, 0, 0,         0, 5};
        vecs[13] = '{0,  0, 0,  0,  0,  0, 0,          0, 0,         1,  4, 'habc,     0, 0,  0, 0,          0,  0, 0,        0, 0, 0, 0,         0, 5};
        vecs[14] = '{0,  0, 0,  0,  0,  0, 0,          0, 0,         0,  0, 0,         0, 0,  0, 0,          0,  0, 0,        0, 4, 0, 0,         1, 5};
        vecs[15] = '{1,  1, 0,  1,  0,  0, 0,          0, 0,         0,  0, 0,         0, 0,  0, 0,          0,  0, 0,        0, 0, 0, 0,         0, 6};
        vecs[16] = '{0,  0, 0,  0,  1,  5, 0,          1, 'h200,     0,  0, 0,         0, 0,  0, 0,          0,  0, 0,        0, 0, 0, 0,         0, 6};
        vecs[17] = '{0,  0, 0,  0,  0,  0, 0,          0, 0,         0,  0, 0,         0, 0,  0, 0,          0,  0, 0,        0, 0, 0, 0,         0, 6};

        idle();
        rst_in = 1'b1;
        step();
        step();
        rst_in = 1'b0;
        chk("rst.full", 32'(rob_full_out), 32'd0);
        chk("rst.tail", 32'(de_rob_idx_out), 32'd0);
        chk("rst.pc", rollback_pc_out, 32'd0);
        chk("rst.val", rob_val_out, 32'd0);
        chk_quiet("rst");

        for (int i = 0; i < 18; i++) begin
            idle();
            de_in_en = 1'(vecs[i].de_en); de_type_in = 2'(vecs[i].ty);
            de_dest_in = 5'(vecs[i].dest); de_pred_jump_in = 1'(vecs[i].pred);
            alu_en = 1'(vecs[i].a_en); alu_idx = 4'(vecs[i].a_idx); alu_val = 32'(vecs[i].a_val);
            alu_jump = 1'(vecs[i].a_jump); alu_target = 32'(vecs[i].a_tgt);
            lsb_en = 1'(vecs[i].l_en); lsb_idx = 4'(vecs[i].l_idx); lsb_val = 32'(vecs[i].l_val);
            rs1_dep_in = 4'(vecs[i].rs1); rs2_dep_in = 4'(vecs[i].rs2);
            #1;
            if (vecs[i].lk != 0) begin
                chk($sformatf("v%0d.busy1", i), 32'(rob_rs1_busy_out), 32'(vecs[i].b1));
                chk($sformatf("v%0d.val1", i), rob_rs1_val_out, 32'(vecs[i].v1));
                chk($sformatf("v%0d.busy2", i), 32'(rob_rs2_busy_out), 32'(vecs[i].b2));
                chk($sformatf("v%0d.val2", i), rob_rs2_val_out, 32'(vecs[i].v2));
            end
            step();
            chk($sformatf("v%0d.rob_in_en", i), 32'(rob_in_en), 32'(vecs[i].we));
            chk($sformatf("v%0d.store", i), 32'(store_commit_out), 32'(vecs[i].st));
            chk($sformatf("v%0d.roll_back", i), 32'(roll_back), 32'd0);
            chk($sformatf("v%0d.tail", i), 32'(de_rob_idx_out), 32'(vecs[i].tail));
            chk($sformatf("v%0d.full", i), 32'(rob_full_out), 32'd0);
            if (vecs[i].we != 0) begin
                chk($sformatf("v%0d.idx", i), 32'(rob_idx_out), 32'(vecs[i].idx));
                chk($sformatf("v%0d.dest", i), 32'(rob_dest_out), 32'(vecs[i].wdest));
                chk($sformatf("v%0d.wval", i), rob_val_out, 32'(vecs[i].wval));
            end
            if (vecs[i].st != 0)
                chk($sformatf("v%0d.store_idx", i), 32'(store_idx_out), 32'(vecs[i].idx));
        end

        // Fill, wrap, and allocate-while-committing from full.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            alloc(2'd0, 5'(i), 1'b0);
            step();
            chk($sformatf("fill%0d.full", i), 32'(rob_full_out), (i == 15) ? 32'd1 : 32'd0);
        end
        chk("fill.tail_wrap", 32'(de_rob_idx_out), 32'd0);
        alu(4'd0, 32'hA0, 1'b0, 32'd0);
        step();
        chk("fill.still_full", 32'(rob_full_out), 32'd1);
        idle();
        step();
        chk_commit("fill.c0", 0, 0, 32'hA0);
        chk("fill.full_drop", 32'(rob_full_out), 32'd0);
        chk("fill.next_idx", 32'(de_rob_idx_out), 32'd0);
        alloc(2'd0, 5'd20, 1'b0);
        step();
        chk("fill.refull", 32'(rob_full_out), 32'd1);
        chk("fill.tail1", 32'(de_rob_idx_out), 32'd1);
        alu(4'd1, 32'hB1, 1'b0, 32'd0);
        step();
        alloc(2'd0, 5'd21, 1'b0);
        step();
        chk_commit("fill.c1", 1, 1, 32'hB1);
        chk("fill.full_kept", 32'(rob_full_out), 32'd1);
        chk("fill.tail2", 32'(de_rob_idx_out), 32'd2);

        // Mispredicted branch with a younger completed REG behind it.
        do_reset();
        alloc(2'd1, 5'd0, 1'b0);
        step();
        alloc(2'd0, 5'd9, 1'b0);
        step();
        alu(4'd1, 32'h55, 1'b0, 32'd0);
        step();
        alu(4'd0, 32'd0, 1'b1, 32'h100);
        step();
        chk_quiet("rb.pre");
        idle();
        step();
        chk("rb.roll_back", 32'(roll_back), 32'd1);
        chk("rb.pc", rollback_pc_out, 32'h100);
        chk("rb.rob_in_en", 32'(rob_in_en), 32'd0);
        chk("rb.tail", 32'(de_rob_idx_out), 32'd0);
        alloc(2'd0, 5'd3, 1'b0);
        step();
        chk("rb.one_cycle", 32'(roll_back), 32'd0);
        chk("rb.pc_clr", rollback_pc_out, 32'd0);
        chk("rb.alloc_ignored", 32'(de_rob_idx_out), 32'd0);
        chk("rb.no_commit", 32'(rob_in_en), 32'd0);
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            chk_quiet($sformatf("rb.after%0d", i));
        end

        // Out-of-order completion and a three-cycle stall.
        do_reset();
        alloc(2'd0, 5'd1, 1'b0);
        step();
        alloc(2'd0, 5'd2, 1'b0);
        step();
        alu(4'd1, 32'h31, 1'b0, 32'd0);
        step();
        chk_quiet("ooo.wait");
        idle();
        lsb_en = 1'b1; lsb_idx = 4'd0; lsb_val = 32'h30;
        step();
        chk_quiet("ooo.wait2");
        idle();
        rdy_in = 1'b0;
        de_in_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_quiet($sformatf("stall%0d", i));
            chk($sformatf("stall%0d.tail", i), 32'(de_rob_idx_out), 32'd2);
        end
        idle();
        step();
        chk_commit("ooo.c0", 0, 1, 32'h30);
        step();
        chk_commit("ooo.c1", 1, 2, 32'h31);
        step();
        chk_quiet("ooo.done");

        // Reset with five live entries and a ready head.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            alloc(2'd0, 5'(i + 10), 1'b0);
            step();
        end
        alu(4'd0, 32'hCC, 1'b0, 32'd0);
        step();
        alu(4'd1, 32'hDD, 1'b0, 32'd0);
        rdy_in = 1'b0;
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        idle();
        chk_quiet("rst5");
        chk("rst5.tail", 32'(de_rob_idx_out), 32'd0);
        chk("rst5.full", 32'(rob_full_out), 32'd0);
        chk("rst5.idx", 32'(rob_idx_out), 32'd0);
        chk("rst5.dest", 32'(rob_dest_out), 32'd0);
        chk("rst5.val", rob_val_out, 32'd0);
        chk("rst5.pc", rollback_pc_out, 32'd0);
        step();
        chk_quiet("rst5.after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
